opl3_stereo_mixer: RTL
======================

Name: opl3_stereo_mixer

Overview:
- Parametrised successor to the fixed 4-channel digital sum at the OPL3 output.
- Takes NUM_SRC signed sample streams, applies per-source gain and L/R pan, accumulates time-multiplexed (one multiply per cycle), then shifts, saturates and presents a stereo sample on a valid/ready interface.
- Sits between the channel engine (or several engines) and the DAC/audio path, in the opl3 clk domain.

Parameters:
- NUM_SRC, 4: number of input sample streams, >=1.
- IN_WIDTH, 16: signed input sample width.
- OUT_WIDTH, 16: signed output sample width.
- GAIN_WIDTH, 8: unsigned per-source gain width; unity gain = 2**(GAIN_WIDTH-1).
- LEFT_SHIFT, 0: extra arithmetic left shift applied before saturation.

Ports:
- clk  in  1  opl3 clock; the only clock.
- ic_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample set valid.
- in_ready  out  1  block can accept a sample set.
- in_sample  in  NUM_SRC*IN_WIDTH  signed samples; source k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- gain  in  NUM_SRC*GAIN_WIDTH  unsigned gain per source.
- pan  in  NUM_SRC*2  per source: bit0 = route to left, bit1 = route to right.
- out_valid  out  1  stereo sample valid.
- out_ready  in  1  consumer accepts the sample.
- sample_l  out  OUT_WIDTH  signed left output.
- sample_r  out  OUT_WIDTH  signed right output.
- clip_l  out  1  sticky: left saturated.
- clip_r  out  1  sticky: right saturated.
- overrun  out  1  sticky: in_valid seen while in_ready was low.
- clr_flags  in  1  clears the sticky flags.

Behaviour:
- Reset, asynchronous, while ic_n is low:
  - state = IDLE.
  - in_ready = 1 after reset.
  - out_valid, sample_l, sample_r, clip_l, clip_r, overrun all 0.
  - Accumulators cleared.
  - An in-progress computation is discarded.
- States: IDLE -> ACCUM -> SAT -> IDLE.
- IDLE:
  - in_ready = 1; in_ready is 0 in every other state.
  - When in_valid is high, latch in_sample, gain and pan, clear both accumulators, set index = 0, go to ACCUM.
  - Later changes on the inputs do not affect the result.
- ACCUM: one source per cycle, NUM_SRC cycles.
  - prod = signed(sample[index]) * {1'b0, gain[index]}, width IN_WIDTH+GAIN_WIDTH+1.
  - acc_l += prod if pan[index][0] is set.
  - acc_r += prod if pan[index][1] is set.
  - Accumulator width is IN_WIDTH+GAIN_WIDTH+1+clog2(NUM_SRC+1), so the accumulators never overflow.
  - After index = NUM_SRC-1, go to SAT.
- SAT:
  - v = (acc >>> (GAIN_WIDTH-1)) <<< LEFT_SHIFT. The right shift is arithmetic, so it floors toward -inf.
  - Clamp v to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
  - If the output slot is free (out_valid==0, or out_ready==1 in the same cycle): load sample_l/sample_r, set out_valid = 1, set clip_l/clip_r if clamping occurred, go to IDLE.
  - Otherwise stall in SAT, holding the accumulators.
- Latency: accept in cycle T, so ACCUM runs in T+1..T+NUM_SRC and SAT in T+NUM_SRC+1. With no stall, out_valid is high from T+NUM_SRC+2. Minimum throughput is one sample set every NUM_SRC+2 cycles.
- Output handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid drops the next cycle unless SAT loads a new sample in the same cycle (back-to-back allowed).
  - sample_l/sample_r hold stable while out_valid && !out_ready.
- Overrun: in_valid && !in_ready sets overrun. That sample set is dropped, with no other effect.
- clr_flags clears clip_l, clip_r and overrun. If set and clear occur in the same cycle, set wins.
- Pan 2'b00 excludes the source from both sums. Gain 0 also excludes it. With pan 2'b11 the source goes to both sums.

Test Plan:
- Match legacy sum: NUM_SRC=4, all gains 128, pan = {R,L,R,L} (src0 L, src1 R, src2 L, src3 R), samples 1000/−300/500/700 -> sample_l=1500, sample_r=400, out_valid high exactly 6 cycles after the accept cycle, no flags set.
- Floor rounding: one source, sample −1001, gain 64, pan L -> sample_l=−501, sample_r=0. Same with sample +1001 -> sample_l=500.
- Saturation: all four sources 32767, gain 255, pan 2'b11 -> sample_l=sample_r=32767, clip_l=clip_r=1. All sources −32768 -> both outputs −32768. clr_flags pulse -> both clip flags 0.
- Backpressure: out_ready held low, two sample sets sent:
  - The second sample set is accepted and then stalls in SAT, with in_ready low.
  - A third in_valid sets overrun.
  - The first output stays stable until out_ready rises.
  - The second output appears in the cycle after that handshake.
- Reset mid-ACCUM: assert ic_n low at index 2 -> all outputs 0 immediately (asynchronous). After release, in_ready=1 and a fresh sample set produces the correct result with no residue from the aborted one.
- Parametrisation: NUM_SRC=1, then NUM_SRC=8 with OUT_WIDTH=24 and LEFT_SHIFT=2. Results match a golden model over 1000 random sample sets, with random out_ready and random gain/pan.

Source files
------------

// File: rtl/opl3_stereo_mixer.sv
// Stereo mixer for OPL3 sample streams: per-source gain and pan, time-multiplexed
// accumulation (one multiply per cycle), then shift, saturate and valid/ready output.
module opl3_stereo_mixer #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 8,
  parameter int unsigned LEFT_SHIFT = 0
) (
  input  logic                             clk,
  input  logic                             ic_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_SRC*IN_WIDTH-1:0]      in_sample,
  input  logic [NUM_SRC*GAIN_WIDTH-1:0]    gain,
  input  logic [NUM_SRC*2-1:0]             pan,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             sample_l,
  output logic [OUT_WIDTH-1:0]             sample_r,
  output logic                             clip_l,
  output logic                             clip_r,
  output logic                             overrun,
  input  logic                             clr_flags
);

  localparam int unsigned PW = IN_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned AW = PW + $clog2(NUM_SRC + 1);
  // Saturation works on a value at least one bit wider than the output.
  localparam int unsigned VW = (AW + LEFT_SHIFT > OUT_WIDTH) ? AW + LEFT_SHIFT : OUT_WIDTH + 1;
  localparam int unsigned CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NUM_SRC - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StSat} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   idx_q, idx_d;
  logic [NUM_SRC*IN_WIDTH-1:0]     smp_q, smp_d;
  logic [NUM_SRC*GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic [NUM_SRC*2-1:0]            pan_q, pan_d;
  logic signed [AW-1:0]            acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic                            out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]            sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                            clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                            overrun_q, overrun_d;

  logic signed [PW-1:0]            s_ext, g_ext, prod;
  logic signed [AW-1:0]            prod_ext;
  logic [OUT_WIDTH:0]              sat_l, sat_r;

  // Returns {clipped, clamped sample}.
  function automatic logic [OUT_WIDTH:0] saturate(logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    logic signed [VW-1:0] v;
    logic                 pos_ovf, neg_ovf;
    sh      = acc >>> (GAIN_WIDTH - 1);
    v       = VW'(sh) <<< LEFT_SHIFT;
    pos_ovf = !v[VW-1] && (|v[VW-2:OUT_WIDTH-1]);
    neg_ovf = v[VW-1] && !(&v[VW-2:OUT_WIDTH-1]);
    if (pos_ovf) begin
      saturate = {2'b10, {(OUT_WIDTH-1){1'b1}}};
    end else if (neg_ovf) begin
      saturate = {2'b11, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      saturate = {1'b0, v[OUT_WIDTH-1:0]};
    end
  endfunction

  // Latched sets are shifted down one source per ACCUM cycle, so source idx sits in the low slot.
  assign s_ext    = {{(GAIN_WIDTH+1){smp_q[IN_WIDTH-1]}}, smp_q[IN_WIDTH-1:0]};
  assign g_ext    = {{(IN_WIDTH+1){1'b0}}, gain_q[GAIN_WIDTH-1:0]};
  assign prod     = s_ext * g_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign sat_l    = saturate(acc_l_q);
  assign sat_r    = saturate(acc_r_q);

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign sample_l  = sample_l_q;
  assign sample_r  = sample_r_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    smp_d       = smp_q;
    gain_d      = gain_q;
    pan_d       = pan_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    out_valid_d = out_valid_q && !out_ready;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    clip_l_d    = clr_flags ? 1'b0 : clip_l_q;
    clip_r_d    = clr_flags ? 1'b0 : clip_r_q;
    overrun_d   = clr_flags ? 1'b0 : overrun_q;
    if (in_valid && !in_ready) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          smp_d   = in_sample;
          gain_d  = gain;
          pan_d   = pan;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (pan_q[0]) acc_l_d = acc_l_q + prod_ext;
        if (pan_q[1]) acc_r_d = acc_r_q + prod_ext;
        smp_d  = smp_q >> IN_WIDTH;
        gain_d = gain_q >> GAIN_WIDTH;
        pan_d  = pan_q >> 2;
        if (idx_q == LastIdx) begin
          state_d = StSat;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      StSat: begin
        if (!out_valid_q || out_ready) begin
          sample_l_d  = sat_l[OUT_WIDTH-1:0];
          sample_r_d  = sat_r[OUT_WIDTH-1:0];
          out_valid_d = 1'b1;
          if (sat_l[OUT_WIDTH]) clip_l_d = 1'b1;
          if (sat_r[OUT_WIDTH]) clip_r_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      smp_q       <= '0;
      gain_q      <= '0;
      pan_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      out_valid_q <= 1'b0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      smp_q       <= smp_d;
      gain_q      <= gain_d;
      pan_q       <= pan_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      out_valid_q <= out_valid_d;
      sample_l_q  <= sample_l_d;
      sample_r_q  <= sample_r_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule
